// File: rtl/word_matcher_if.sv
// Symbol stream, pattern config and match/counter bundle for word_matcher.
interface word_matcher_if #(
  parameter int SYM_W   = 3,
  parameter int MAX_LEN = 4,
  parameter int NUM_PAT = 3,
  parameter int CNT_W   = 8
);
  logic                      restart;
  logic [SYM_W-1:0]          bits;
  logic                      cfg_we;
  logic [3:0]                cfg_idx;
  logic [3:0]                cfg_len;
  logic [MAX_LEN*SYM_W-1:0]  cfg_pat;
  logic                      cnt_clr;
  logic [NUM_PAT-1:0]        match;
  logic [NUM_PAT*CNT_W-1:0]  count;

  modport master (
    output restart, bits, cfg_we, cfg_idx, cfg_len, cfg_pat, cnt_clr,
    input  match, count
  );
  modport slave (
    input  restart, bits, cfg_we, cfg_idx, cfg_len, cfg_pat, cnt_clr,
    output match, count
  );
endinterface

// File: rtl/word_matcher.sv
// Delimited-word recogniser: one independent tracker per programmable pattern,
// each with a registered match pulse and a saturating match counter.
module word_matcher_lane #(
  parameter int SYM_W   = 3,
  parameter int MAX_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     restart,
  input  logic [SYM_W-1:0]         bits,
  input  logic                     load,
  input  logic [3:0]               cfg_len,
  input  logic [MAX_LEN*SYM_W-1:0] cfg_pat,
  input  logic                     cnt_clr,
  output logic                     match,
  output logic [CNT_W-1:0]         count
);
  logic                            armed, armed_d, match_d;
  logic [3:0]                      pos, pos_d, len;
  logic [MAX_LEN-1:0][SYM_W-1:0]   pat;
  logic [SYM_W-1:0]                cur_sym;

  // Mux out the symbol expected at the current position.
  always_comb begin
    cur_sym = '0;
    for (int k = 0; k < MAX_LEN; k++)
      if (pos == 4'(k)) cur_sym = pat[k];
  end

  always_comb begin
    armed_d = armed;
    pos_d   = pos;
    match_d = 1'b0;
    if (restart) begin
      armed_d = 1'b1;
      pos_d   = '0;
    end else if (load) begin
      armed_d = 1'b0;
      pos_d   = '0;
    end else if (bits == '0) begin
      match_d = armed && (len != '0) && (pos == len);
      armed_d = 1'b1;
      pos_d   = '0;
    end else if (armed && (pos < len) && (bits == cur_sym)) begin
      pos_d   = pos + 4'd1;
    end else begin
      // Wrong symbol or overlong word: dead until the next delimiter.
      armed_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed <= 1'b0;
      pos   <= '0;
      len   <= '0;
      pat   <= '0;
      match <= 1'b0;
      count <= '0;
    end else begin
      armed <= armed_d;
      pos   <= pos_d;
      match <= match_d;
      if (load && !restart) begin
        len <= (cfg_len > 4'(MAX_LEN)) ? 4'd0 : cfg_len;
        pat <= cfg_pat;
      end
      if (cnt_clr)
        count <= '0;
      else if (match_d && (count != '1))
        count <= count + CNT_W'(1);
    end
  end
endmodule

module word_matcher #(
  parameter int SYM_W   = 3,
  parameter int MAX_LEN = 4,
  parameter int NUM_PAT = 3,
  parameter int CNT_W   = 8
) (
  input logic         clk,
  input logic         reset,
  word_matcher_if.slave bus
);
  logic [NUM_PAT-1:0]            match;
  logic [NUM_PAT-1:0][CNT_W-1:0] count;

  for (genvar i = 0; i < NUM_PAT; i++) begin : g_lane
    word_matcher_lane #(
      .SYM_W   (SYM_W),
      .MAX_LEN (MAX_LEN),
      .CNT_W   (CNT_W)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .restart (bus.restart),
      .bits    (bus.bits),
      .load    (bus.cfg_we && (bus.cfg_idx == 4'(i))),
      .cfg_len (bus.cfg_len),
      .cfg_pat (bus.cfg_pat),
      .cnt_clr (bus.cnt_clr),
      .match   (match[i]),
      .count   (count[i])
    );
  end

  assign bus.match = match;
  assign bus.count = count;
endmodule
